ssd_scan_decoder: RTL and testbench

//  Receive side of the two-digit seven-segment display interface. Samples a time-multiplexed

---
 rtl/ssd_scan_decoder.sv | 180 ++++++++++++++++++
 tb/tb_ssd_scan_decoder.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/ssd_scan_decoder.sv
// Receive side of the two-digit seven-segment display bus: debounces each multiplexed
// digit, converts the captured pattern pair to 0..31 and offers it on a valid/ready port.
module ssd_scan_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg_in,
  input  logic [1:0] dig_en,
  output logic [4:0] value_out,
  output logic       value_valid,
  input  logic       value_ready,
  output logic       value_err,
  output logic [1:0] err_code
);

  typedef enum logic [1:0] {
    COLLECT = 2'b00,
    DECODE  = 2'b01,
    HOLD    = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CAP_CNT = CNT_W'(STABLE_CYCLES - 1);

  // Returns {illegal, digit} for a ones-position pattern.
  function automatic logic [4:0] ones_decode(input logic [6:0] seg);
    case (seg)
      7'b0000001: ones_decode = 5'b0_0000;
      7'b1001111: ones_decode = 5'b0_0001;
      7'b0010010: ones_decode = 5'b0_0010;
      7'b0000110: ones_decode = 5'b0_0011;
      7'b1001100: ones_decode = 5'b0_0100;
      7'b0100100: ones_decode = 5'b0_0101;
      7'b0100000: ones_decode = 5'b0_0110;
      7'b0001111: ones_decode = 5'b0_0111;
      7'b0000000: ones_decode = 5'b0_1000;
      7'b0000100: ones_decode = 5'b0_1001;
      default:    ones_decode = 5'b1_0000;
    endcase
  endfunction

  // Returns {illegal, digit}; a blank tens position reads as zero, a lit '0' is illegal.
  function automatic logic [2:0] tens_decode(input logic [6:0] seg);
    case (seg)
      7'b1111111: tens_decode = 3'b0_00;
      7'b1001111: tens_decode = 3'b0_01;
      7'b0010010: tens_decode = 3'b0_10;
      7'b0000110: tens_decode = 3'b0_11;
      default:    tens_decode = 3'b1_00;
    endcase
  endfunction

  state_t           state_q, state_d;
  logic [6:0]       prev_seg_q;
  logic [1:0]       prev_en_q;
  logic [CNT_W-1:0] stab_cnt_q, stab_cnt_d;
  logic [6:0]       ones_q, tens_q;
  logic             ones_vld_q, tens_vld_q;
  logic [4:0]       value_q;
  logic             valid_q, err_q;
  logic [1:0]       code_q;

  logic             eligible_s, same_s, capture_s, accept_s;
  logic [4:0]       ones_dec_s;
  logic [2:0]       tens_dec_s;
  logic [4:0]       dec_value_s;
  logic             dec_err_s;
  logic [1:0]       dec_code_s;

  assign eligible_s = (dig_en == 2'b01) || (dig_en == 2'b10);
  assign same_s     = (seg_in == prev_seg_q) && (dig_en == prev_en_q);
  assign accept_s   = valid_q && value_ready;
  assign ones_dec_s = ones_decode(ones_q);
  assign tens_dec_s = tens_decode(tens_q);

  // Saturating run-length counter; it never re-reaches CAP_CNT within one run.
  always_comb begin
    stab_cnt_d = {CNT_W{1'b0}};
    if (state_q != COLLECT) begin
      stab_cnt_d = {CNT_W{1'b0}};
    end else if (eligible_s && same_s) begin
      stab_cnt_d = (stab_cnt_q == CNT_MAX) ? stab_cnt_q : stab_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stab_cnt_d = {CNT_W{1'b0}};
    end
  end

  assign capture_s = (state_q == COLLECT) && eligible_s && (stab_cnt_d == CAP_CNT);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COLLECT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      COLLECT: state_d = (ones_vld_q && tens_vld_q) ? DECODE : COLLECT;
      DECODE:  state_d = HOLD;
      HOLD:    state_d = accept_s ? COLLECT : HOLD;
      default: state_d = COLLECT;
    endcase
  end

  // Output logic: decoded result of the captured pair, with error priority ones > tens > range.
  always_comb begin
    dec_value_s = 5'd0;
    dec_err_s   = 1'b0;
    dec_code_s  = 2'b00;
    if (ones_dec_s[4]) begin
      dec_err_s  = 1'b1;
      dec_code_s = 2'b01;
    end else if (tens_dec_s[2]) begin
      dec_err_s  = 1'b1;
      dec_code_s = 2'b10;
    end else if ((tens_dec_s[1:0] == 2'd3) && (ones_dec_s[3:0] > 4'd1)) begin
      dec_err_s  = 1'b1;
      dec_code_s = 2'b11;
    end else begin
      dec_value_s = ({3'b000, tens_dec_s[1:0]} * 5'd10) + {1'b0, ones_dec_s[3:0]};
    end
  end

  // Sampling history, digit capture and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_seg_q <= 7'd0;
      prev_en_q  <= 2'd0;
      stab_cnt_q <= {CNT_W{1'b0}};
      ones_q     <= 7'd0;
      tens_q     <= 7'd0;
      ones_vld_q <= 1'b0;
      tens_vld_q <= 1'b0;
      value_q    <= 5'd0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      code_q     <= 2'b00;
    end else begin
      prev_seg_q <= seg_in;
      prev_en_q  <= dig_en;
      stab_cnt_q <= stab_cnt_d;
      if (capture_s && dig_en[0]) begin
        ones_q     <= seg_in;
        ones_vld_q <= 1'b1;
      end else if (capture_s) begin
        tens_q     <= seg_in;
        tens_vld_q <= 1'b1;
      end else if ((state_q == HOLD) && accept_s) begin
        ones_vld_q <= 1'b0;
        tens_vld_q <= 1'b0;
      end else begin
        ones_vld_q <= ones_vld_q;
        tens_vld_q <= tens_vld_q;
      end
      if (state_q == DECODE) begin
        value_q <= dec_value_s;
        err_q   <= dec_err_s;
        code_q  <= dec_code_s;
        valid_q <= 1'b1;
      end else if ((state_q == HOLD) && accept_s) begin
        valid_q <= 1'b0;
      end else begin
        valid_q <= valid_q;
      end
    end
  end

  assign value_out   = value_q;
  assign value_valid = valid_q;
  assign value_err   = err_q;
  assign err_code    = code_q;

endmodule

// File: tb/tb_ssd_scan_decoder.sv
// Randomized bench for ssd_scan_decoder: drives digit runs and compares against a
// table-lookup model of which patterns get captured and what value they mean.
module tb_ssd_scan_decoder;
  localparam int S = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] seg_in = 7'h7F;
  logic [1:0] dig_en = 2'b00;
  logic       value_ready = 1'b0;
  logic [4:0] value_out;
  logic       value_valid;
  logic       value_err;
  logic [1:0] err_code;

  ssd_scan_decoder #(.STABLE_CYCLES(S), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .dig_en(dig_en),
    .value_out(value_out), .value_valid(value_valid), .value_ready(value_ready),
    .value_err(value_err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  logic [6:0] tbl [0:9];
  logic [6:0] m_tens, m_ones;
  bit m_tv, m_ov, seen_valid;
  int rise_cyc, last_cap;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One sample period: inputs change on the falling edge, DUT samples on the next rising edge.
  task automatic step(input logic [6:0] s, input logic [1:0] e);
    @(negedge clk);
    if (value_valid && !seen_valid) begin
      seen_valid = 1'b1;
      rise_cyc   = cyc;
    end
    seg_in = s;
    dig_en = e;
  endtask

  // A run of identical samples followed by one idle sample; the model captures runs of S or more.
  task automatic run_model(input logic [6:0] s, input logic [1:0] e, input int len);
    for (int i = 0; i < len; i++) begin
      step(s, e);
      if (i == S - 1) last_cap = cyc + 1;
    end
    if (len >= S && e == 2'b01) begin m_ones = s; m_ov = 1'b1; end
    if (len >= S && e == 2'b10) begin m_tens = s; m_tv = 1'b1; end
    step(7'h7F, 2'b00);
  endtask

  task automatic add_noise();
    int kind;
    repeat ($urandom_range(1, 3)) begin
      kind = $urandom_range(0, 2);
      if (kind == 0) run_model(7'($urandom), 2'b11, $urandom_range(1, 10));
      else if (kind == 1) run_model(7'($urandom), 2'b01, $urandom_range(1, S - 1));
      else run_model(7'($urandom), 2'b10, $urandom_range(1, S - 1));
    end
  endtask

  function automatic void expect_of(input logic [6:0] tp, input logic [6:0] op,
                                    output int v, output int e, output int c);
    int o = -1;
    int t = -1;
    for (int i = 0; i < 10; i++) if (tbl[i] == op) o = i;
    if (tp == 7'h7F) t = 0;
    for (int i = 1; i < 4; i++) if (tbl[i] == tp) t = i;
    if (o < 0)                 begin v = 0; e = 1; c = 1; end
    else if (t < 0)            begin v = 0; e = 1; c = 2; end
    else if (t * 10 + o > 31)  begin v = 0; e = 1; c = 3; end
    else                       begin v = t * 10 + o; e = 0; c = 0; end
  endfunction

  task automatic wait_valid();
    for (int k = 0; k < 20 && !seen_valid; k++) step(7'h7F, 2'b00);
  endtask

  // Completes a transaction whose second digit was captured at edge cap.
  task automatic finish_txn(input int cap, input int hold_n);
    int ev, ee, ec;
    wait_valid();
    check("valid_seen", seen_valid, 1);
    if (seen_valid) check("latency", rise_cyc - cap, 2);
    expect_of(m_tens, m_ones, ev, ee, ec);
    check("value", value_out, ev);
    check("err", value_err, ee);
    check("code", err_code, ec);
    for (int i = 0; i < hold_n; i++) begin
      step(7'($urandom), 2'($urandom));
      check("hold_valid", value_valid, 1);
      check("hold_value", value_out, ev);
    end
    @(negedge clk);
    value_ready = 1'b1;
    seg_in = 7'h7F;
    dig_en = 2'b00;
    @(negedge clk);
    check("valid_drop", value_valid, 0);
    value_ready = 1'b0;
    step(7'h7F, 2'b00);
    step(7'h7F, 2'b00);
  endtask

  task automatic do_txn(input logic [6:0] tp, input logic [6:0] op, input bit ones_first,
                        input bit noisy, input int hold_n);
    logic [1:0] e1, e2;
    logic [6:0] p1, p2;
    e1 = ones_first ? 2'b01 : 2'b10;
    e2 = ~e1;
    p1 = ones_first ? op : tp;
    p2 = ones_first ? tp : op;
    m_ov = 1'b0; m_tv = 1'b0; seen_valid = 1'b0;
    if (noisy) begin
      add_noise();
      run_model(7'($urandom), e1, S + $urandom_range(0, 2));
    end
    run_model(p1, e1, S + $urandom_range(0, 2));
    if (noisy) add_noise();
    check("early_valid", value_valid, 0);
    run_model(p2, e2, S + $urandom_range(0, 2));
    finish_txn(last_cap, hold_n);
  endtask

  initial begin
    logic [6:0] tp, op;
    tbl[0] = 7'b0000001; tbl[1] = 7'b1001111; tbl[2] = 7'b0010010; tbl[3] = 7'b0000110;
    tbl[4] = 7'b1001100; tbl[5] = 7'b0100100; tbl[6] = 7'b0100000; tbl[7] = 7'b0001111;
    tbl[8] = 7'b0000000; tbl[9] = 7'b0000100;
    repeat (3) @(negedge clk);
    check("rst_valid", value_valid, 0);
    check("rst_value", value_out, 0);
    check("rst_err", value_err, 0);
    check("rst_code", err_code, 0);
    rst_n = 1'b1;
    step(7'h7F, 2'b00);

    do_txn(7'h7F, tbl[3], 1'b0, 1'b0, 0);
    do_txn(tbl[2], tbl[0], 1'b0, 1'b0, 0);
    do_txn(tbl[2], tbl[0], 1'b1, 1'b0, 0);
    do_txn(tbl[3], tbl[1], 1'b0, 1'b0, 0);
    do_txn(tbl[3], tbl[2], 1'b0, 1'b0, 0);
    do_txn(tbl[0], tbl[5], 1'b1, 1'b0, 0);
    do_txn(tbl[1], 7'b1111111, 1'b0, 1'b0, 0);

    // Short runs and a both-digits-enabled stretch must not capture anything.
    seen_valid = 1'b0;
    repeat (3) step(tbl[4], 2'b01);
    repeat (3) step(tbl[6], 2'b01);
    repeat (10) step(tbl[6], 2'b11);
    repeat (4) step(7'h7F, 2'b00);
    check("no_capture_valid", seen_valid, 0);

    do_txn(tbl[2], tbl[9], 1'b1, 1'b0, 10);

    // Reset while holding a result.
    m_ov = 1'b0; m_tv = 1'b0; seen_valid = 1'b0;
    run_model(tbl[2], 2'b10, S);
    run_model(tbl[5], 2'b01, S);
    wait_valid();
    check("pre_rst_valid", seen_valid, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", value_valid, 0);
    check("mid_rst_value", value_out, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // A lone tens capture is discarded by reset.
    m_ov = 1'b0; m_tv = 1'b0;
    run_model(tbl[1], 2'b10, S);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_tv = 1'b0; seen_valid = 1'b0;
    run_model(tbl[7], 2'b01, S);
    repeat (10) step(7'h7F, 2'b00);
    check("lone_no_valid", seen_valid, 0);
    run_model(tbl[1], 2'b10, S);
    finish_txn(last_cap, 2);

    for (int n = 0; n < 60; n++) begin
      op = ($urandom_range(0, 9) < 7) ? tbl[$urandom_range(0, 9)] : 7'($urandom);
      if ($urandom_range(0, 9) < 2) tp = 7'($urandom);
      else if ($urandom_range(0, 3) == 0) tp = 7'h7F;
      else tp = tbl[$urandom_range(1, 3)];
      do_txn(tp, op, 1'($urandom), 1'b1, $urandom_range(0, 5));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
